// File: rtl/rx_phy_pkg.sv
// Shared definitions for the lane receive path: COM symbol, receiver states, defaults.
package rx_phy_pkg;
  localparam logic [7:0]  COM_SYM          = 8'hBC;
  localparam int unsigned BC_COUNT_DEF     = 4;
  localparam int unsigned MAX_DATA_RUN_DEF = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNED  = 2'd1,
    ACTIVE   = 2'd2
  } rx_state_t;
endpackage

// File: rtl/com_detector.sv
// Serial shift register, sliding COM compare and the byte-boundary bit counter.
module com_detector
  import rx_phy_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  input  logic       align,
  output logic [7:0] sr,
  output logic       com_hit,
  output logic       boundary
);
  logic [2:0] bit_cnt;

  // align restarts the byte phase so the next full byte lands 8 edges later
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr      <= {sr[6:0], data_in};
      bit_cnt <= align ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  assign com_hit  = (sr == COM_SYM);
  assign boundary = (bit_cnt == 3'd7);
endmodule

// File: rtl/serial_paralelo_rx.sv
// Lane deserializer with COM alignment and link-up detection.
// Optional LOSS_OF_LOCK_EN drops the link after MAX_DATA_RUN back-to-back data bytes.
module serial_paralelo_rx
  import rx_phy_pkg::*;
#(
  parameter int unsigned BC_COUNT     = BC_COUNT_DEF,
  parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);
  localparam int unsigned CW = $clog2(BC_COUNT + 1);

  rx_state_t     state, state_d;
  logic [CW-1:0] com_cnt, com_cnt_d;
  logic [7:0]    sr, data_d;
  logic          com_hit, boundary, align, lock_bnd;
  logic          valid_d, strobe_d, run_max;

  com_detector u_det (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .align    (align),
    .sr       (sr),
    .com_hit  (com_hit),
    .boundary (boundary)
  );

  // the bit counter free-runs while unlocked; only locked boundaries count
  assign lock_bnd = boundary && (state != UNLOCKED);

`ifdef LOSS_OF_LOCK_EN
  localparam int unsigned RW = $clog2(MAX_DATA_RUN + 1);
  logic [RW-1:0] run_cnt, run_cnt_d;

  assign run_max = (run_cnt == RW'(MAX_DATA_RUN));

  always_comb begin
    run_cnt_d = run_cnt;
    if (state != ACTIVE || run_max) run_cnt_d = '0;
    else if (lock_bnd)              run_cnt_d = com_hit ? '0 : run_cnt + RW'(1);
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) run_cnt <= '0;
    else          run_cnt <= run_cnt_d;
  end
`else
  assign run_max = 1'b0;
`endif

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state   <= UNLOCKED;
      com_cnt <= '0;
    end else begin
      state   <= state_d;
      com_cnt <= com_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    com_cnt_d = com_cnt;
    align     = 1'b0;
    case (state)
      UNLOCKED: if (com_hit) begin
        align     = 1'b1;
        com_cnt_d = CW'(1);
        state_d   = (BC_COUNT == 1) ? ACTIVE : ALIGNED;
      end
      ALIGNED: if (boundary) begin
        if (com_hit) begin
          com_cnt_d = com_cnt + CW'(1);
          if (com_cnt == CW'(BC_COUNT - 1)) state_d = ACTIVE;
        end else begin
          state_d   = UNLOCKED;
          com_cnt_d = '0;
        end
      end
      ACTIVE: if (run_max) begin
        state_d   = UNLOCKED;
        com_cnt_d = '0;
      end
      default: begin
        state_d   = UNLOCKED;
        com_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    data_d   = data_out;
    valid_d  = valid_out;
    strobe_d = 1'b0;
    if (lock_bnd) begin
      strobe_d = 1'b1;
      if (state == ACTIVE) begin
        if (com_hit) valid_d = 1'b0;
        else begin
          data_d  = sr;
          valid_d = 1'b1;
        end
      end
    end
    if (state_d != ACTIVE) valid_d = 1'b0;
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      data_out    <= data_d;
      valid_out   <= valid_d;
      byte_strobe <= strobe_d;
      active      <= (state_d == ACTIVE);
    end
  end
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed table + corner sequences, then random traffic vs a cycle model.
module tb_serial_paralelo_rx;
  localparam int BCN  = 4;
  localparam int MAXR = 16;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, byte_strobe, active;

  int checks = 0;
  int errors = 0;

  serial_paralelo_rx #(.BC_COUNT(BCN), .MAX_DATA_RUN(MAXR)) dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference: lock time is remembered as an absolute edge index; boundaries
  // are every 8th cycle after it, found by modular arithmetic.
  int         m_e = 0, m_lock = 0, m_mode = 0, m_coms = 0, m_run = 0;
  logic [7:0] m_win = '0, m_data = '0;
  bit         m_valid = 0, m_strobe = 0, m_active = 0;

  int ecount = 0, rise_e = -1;
  bit prev_act = 0;
  int stb_q[$];

  task automatic model(input bit b, input bit rn);
    bit hit, bnd, drop;
    if (!rn) begin
      m_win = '0; m_mode = 0; m_coms = 0; m_run = 0;
      m_data = '0; m_valid = 0; m_strobe = 0; m_active = 0;
    end else begin
      hit  = (m_win == 8'hBC);
      bnd  = (m_mode != 0) && (m_e > m_lock) && ((m_e - m_lock) % 8 == 0);
      drop = 0;
      m_strobe = bnd;
      case (m_mode)
        0: if (hit) begin
          m_lock = m_e; m_coms = 1; m_run = 0;
          m_mode = (BCN == 1) ? 2 : 1;
        end
        1: if (bnd) begin
          if (hit) begin
            m_coms++;
            if (m_coms == BCN) m_mode = 2;
          end else begin
            m_mode = 0; m_coms = 0;
          end
        end
        default: begin
`ifdef LOSS_OF_LOCK_EN
          if (m_run == MAXR) begin
            drop = 1; m_mode = 0; m_valid = 0; m_coms = 0; m_run = 0;
          end
`endif
          if (!drop && bnd) begin
            if (hit) begin
              m_valid = 0; m_run = 0;
            end else begin
              m_data = m_win; m_valid = 1; m_run++;
            end
          end
        end
      endcase
      m_active = (m_mode == 2);
      m_win = {m_win[6:0], b};
    end
    m_e++;
  endtask

  task automatic step(input bit b, input bit rn);
    data_in = b;
    reset_L = rn;
    @(posedge clk_32f);
    ecount++;
    model(b, rn);
    #1;
    checks++;
    if ({active, valid_out, byte_strobe, data_out} !== {m_active, m_valid, m_strobe, m_data}) begin
      errors++;
      $display("FAIL cycle %0d: got act=%0b vld=%0b stb=%0b data=%02h, want act=%0b vld=%0b stb=%0b data=%02h",
               ecount, active, valid_out, byte_strobe, data_out, m_active, m_valid, m_strobe, m_data);
    end
    if (active === 1'b1 && !prev_act && rise_e < 0) rise_e = ecount;
    prev_act = (active === 1'b1);
    if (byte_strobe === 1'b1) stb_q.push_back(ecount);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255)); while (v == 8'hBC);
    return v;
  endfunction

  typedef struct {
    logic [7:0] b;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_active;
  } vec_t;

  vec_t       tbl[7];
  int         e_last, r;
  logic [7:0] v;

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 1, 1};
    tbl[1] = '{8'h3C, 8'h3C, 1, 1};
    tbl[2] = '{8'hBC, 8'h3C, 0, 1};
    tbl[3] = '{8'h00, 8'h00, 1, 1};
    tbl[4] = '{8'hFF, 8'hFF, 1, 1};
    tbl[5] = '{8'hBC, 8'hFF, 0, 1};
    tbl[6] = '{8'h5A, 8'h5A, 1, 1};

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_outputs", int'({active, valid_out, byte_strobe, data_out}), 0);

    // junk bits, then lock on four COMs
    repeat (3) step(1'b0, 1'b1);
    repeat (4) send_byte(8'hBC);
    e_last = ecount;
    chk("pre_active", int'(active), 0);
    stb_q.delete();
    rise_e = -1;

    // each row's result is visible while the following byte is shifting in
    for (int i = 0; i <= 7; i++) begin
      send_byte(i < 7 ? tbl[i].b : 8'h11);
      if (i > 0) begin
        chk("tbl_data",   int'(data_out),  int'(tbl[i-1].exp_data));
        chk("tbl_valid",  int'(valid_out), int'(tbl[i-1].exp_valid));
        chk("tbl_active", int'(active),    int'(tbl[i-1].exp_active));
      end
    end
    chk("active_rise_edge", rise_e, e_last + 1);
    chk("first_strobe_edge", stb_q.size() > 0 ? stb_q[0] : -1, e_last + 1);
    chk("strobe_period", stb_q.size() > 1 ? stb_q[1] - stb_q[0] : -1, 8);

    // three COMs then data: falls back to searching, never goes active
    step(1'b0, 1'b0);
    repeat (3) send_byte(8'hBC);
    send_byte(8'h00);
    chk("partial_lock_inactive", int'(active), 0);
    repeat (4) send_byte(8'hBC);
    send_byte(8'h42);
    chk("relock_active", int'(active), 1);
    chk("relock_valid", int'(valid_out), 0);

    // reset in the middle of a byte while active
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("midbyte_reset", int'({active, valid_out, byte_strobe, data_out}), 0);
    repeat (3) send_byte(8'hBC);
    send_byte(8'h42);
    chk("reset_3com_inactive", int'(active), 0);
    repeat (4) send_byte(8'hBC);
    send_byte(8'h42);
    chk("reset_relock", int'(active), 1);

`ifdef LOSS_OF_LOCK_EN
    send_byte(8'hBC);
    repeat (15) send_byte(rand_data());
    send_byte(8'hBC);
    send_byte(rand_data());
    chk("run15_com_active", int'(active), 1);
    send_byte(8'hBC);
    repeat (15) send_byte(rand_data());
    v = rand_data();
    send_byte(v);
    step(1'b0, 1'b1);
    chk("run16_valid", int'(valid_out), 1);
    chk("run16_data", int'(data_out), int'(v));
    chk("run16_still_active", int'(active), 1);
    step(1'b0, 1'b1);
    chk("run16_drop_active", int'(active), 0);
    chk("run16_drop_valid", int'(valid_out), 0);
`else
    repeat (20) send_byte(rand_data());
    chk("sticky_active", int'(active), 1);
    chk("sticky_valid", int'(valid_out), 1);
`endif

    // random traffic: COMs, data, bit slips and occasional resets
    step(1'b0, 1'b0);
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 3)       step(1'($urandom_range(0, 1)), 1'b0);
      else if (r < 10) step(1'($urandom_range(0, 1)), 1'b1);
      else if (r < 55) send_byte(8'hBC);
      else             send_byte(8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
